ram_n: RTL and testbench
========================

Name: ram_n

Overview:
- Parametrised general-purpose data memory; successor to the fixed 8×16 RAM.
- Width and depth are configurable.
- Adds a second combinational read port, a hardware zero-fill sequencer that runs after reset and on request, and a busy flag.
- Sits in the data-memory path of the CPU. It is also the building block for larger RAM hierarchies.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_BITS, 3, address width; DEPTH = 2**ADDR_BITS words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  write enable, sampled on the rising edge of clk.
- address  input  ADDR_BITS  write address and port-A read address.
- in  input  WIDTH  write data.
- out  output  WIDTH  port-A read data, combinational.
- address_b  input  ADDR_BITS  port-B read address.
- out_b  output  WIDTH  port-B read data, combinational.
- clear  input  1  synchronous zero-fill request, sampled on the rising edge.
- busy  output  1  high while the zero-fill sequencer runs.

Behaviour:
- State: mem[0..DEPTH-1] of WIDTH bits; fsm in {CLEAR, IDLE}; ptr of ADDR_BITS bits.
- Reset (asynchronous, level):
  - While reset=1: fsm=CLEAR, ptr=0, busy=1, out=0, out_b=0.
  - No memory write occurs while reset is high.
- CLEAR state:
  - Each rising edge with reset=0: mem[ptr]<=0 and ptr<=ptr+1.
  - On the edge where ptr==DEPTH-1, that word is written to 0, ptr wraps to 0 and fsm<=IDLE.
  - Result: busy stays high for exactly DEPTH rising edges after reset falls, and drops immediately after the DEPTH-th edge.
  - load is ignored; in is never written.
  - clear=1 at an edge restarts the sweep: ptr<=0, no increment.
  - out and out_b are forced to 0 while busy=1.
- IDLE state:
  - busy=0.
  - load=1 at an edge: mem[address]<=in.
  - clear=1 at an edge: fsm<=CLEAR, ptr<=0. If clear and load are both high on the same edge, clear wins and no write occurs.
- Read ports:
  - out = mem[address] and out_b = mem[address_b], purely combinational; no read latency.
  - A written value appears on either port after the writing edge, never before it.
  - Port A and port B may address the same word; both return the same value.
- Reset mid-operation: asserting reset at any point, including mid-sweep, aborts the current activity. The full DEPTH-cycle sweep restarts after release; partially written state is irrelevant.
- Width rules:
  - address and address_b index the full range 0..DEPTH-1; there is no out-of-range case.
  - ptr wraps modulo DEPTH.
- Every write takes exactly one edge.
- No X may reach out or out_b after the first post-reset sweep completes.

Test Plan:
- Reset sweep (defaults): hold reset=1 for 2 cycles, then release. Required: busy=1 and out=0 for exactly 8 rising edges, then busy=0. Reading addresses 0..7 on both ports returns 0x0000.
- Write/read: in IDLE, address=3, in=0x1234, load=1 for one edge. Required: out=0x0000 before the edge and 0x1234 after it. With address_b=3, out_b=0x1234. Addresses 2 and 4 still read 0x0000.
- Write while busy: during the sweep, address=5, in=0xBEEF, load=1 held. Required: after busy falls, mem[5] reads 0x0000.
- Clear priority: fill addresses 0..7 with 0x0001..0x0008, then assert clear=1 and load=1 (address=0, in=0xFFFF) on the same edge. Required: busy=1 for 8 edges, after which all 8 words read 0x0000.
- Reset mid-sweep: assert reset for 1 cycle when ptr=5. Required: after release, busy stays high for a further 8 full edges.
- Parameter sweep: WIDTH=8, ADDR_BITS=6. Write 0xA5 to address 63 and 0x5A to address 0. Required: after the 64-edge initial sweep, out_b(63)=0xA5, out(0)=0x5A and out(62)=0x00.

Source files
------------

// File: rtl/ram_n.sv
// Parametrised data memory: synchronous write port, two combinational read
// ports, and a zero-fill sequencer that sweeps every word after reset or on request.
module ram_n #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] address,
  input  logic [WIDTH-1:0]     in,
  output logic [WIDTH-1:0]     out,
  input  logic [ADDR_BITS-1:0] address_b,
  output logic [WIDTH-1:0]     out_b,
  input  logic                 clear,
  output logic                 busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t               r_state;
  logic [ADDR_BITS-1:0] r_ptr;
  logic                 r_busy;
  logic [WIDTH-1:0]     r_mem [DEPTH];

  logic                 w_we;
  logic [ADDR_BITS-1:0] w_waddr;
  logic [WIDTH-1:0]     w_wdata;

  // Single write port shared by the sweeper and the user; clear always pre-empts both.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = address;
    w_wdata = in;
    if (!reset) begin
      case (r_state)
        S_CLEAR: begin
          if (!clear) begin
            w_we    = 1'b1;
            w_waddr = r_ptr;
            w_wdata = '0;
          end
        end
        S_IDLE: begin
          if (load && !clear) w_we = 1'b1;
        end
        default: w_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (clear) begin
            r_ptr <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
            if (r_ptr == ADDR_BITS'(DEPTH - 1)) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_IDLE: begin
          if (clear) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Reads are masked while sweeping so stale or uninitialised words never leak out.
  assign out   = r_busy ? '0 : r_mem[address];
  assign out_b = r_busy ? '0 : r_mem[address_b];
  assign busy  = r_busy;

endmodule

// File: tb/tb_ram_n.sv
// Directed bench for ram_n: default 8x16 instance plus a 64x8 instance.
module tb_ram_n;

  logic        clk = 1'b0;
  logic        reset, load, clear;
  logic [2:0]  address, address_b;
  logic [15:0] in_d, out, out_b;
  logic        busy;

  logic        p_reset, p_load, p_clear;
  logic [5:0]  p_address, p_address_b;
  logic [7:0]  p_in, p_out, p_out_b;
  logic        p_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_n dut (
    .clk(clk), .reset(reset), .load(load), .address(address), .in(in_d),
    .out(out), .address_b(address_b), .out_b(out_b), .clear(clear), .busy(busy)
  );

  ram_n #(.WIDTH(8), .ADDR_BITS(6)) dut_p (
    .clk(clk), .reset(p_reset), .load(p_load), .address(p_address), .in(p_in),
    .out(p_out), .address_b(p_address_b), .out_b(p_out_b), .clear(p_clear), .busy(p_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; clear = 1'b0; address = 3'd0; address_b = 3'd0; in_d = 16'h0;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++;
    if (out !== 16'h0 || out_b !== 16'h0) begin
      errors++; $display("FAIL reset_out got %h/%h want 0000/0000", out, out_b);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy !== 1'b1 || out !== 16'h0) begin
        errors++; $display("FAIL sweep_busy edge %0d got busy=%b out=%h want 1/0000", i, busy, out);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sweep_done got %b want 0", busy); end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); address_b = 3'(7 - a);
      #1;
      checks++;
      if (out !== 16'h0 || out_b !== 16'h0) begin
        errors++; $display("FAIL zero_read addr %0d got %h/%h want 0000/0000", a, out, out_b);
      end
    end
  endtask

  task automatic test_write_read();
    address = 3'd3; in_d = 16'h1234; load = 1'b1;
    #1;
    checks++;
    if (out !== 16'h0) begin errors++; $display("FAIL pre_write got %h want 0000", out); end
    tick();
    load = 1'b0; address_b = 3'd3;
    #1;
    checks++;
    if (out !== 16'h1234) begin errors++; $display("FAIL write_a got %h want 1234", out); end
    checks++;
    if (out_b !== 16'h1234) begin errors++; $display("FAIL write_b got %h want 1234", out_b); end
    address = 3'd2; address_b = 3'd4;
    #1;
    checks++;
    if (out !== 16'h0 || out_b !== 16'h0) begin
      errors++; $display("FAIL neighbours got %h/%h want 0000/0000", out, out_b);
    end
  endtask

  task automatic test_write_while_busy();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    address = 3'd5; in_d = 16'hBEEF; load = 1'b1; address_b = 3'd3;
    tick();
    checks++;
    if (out_b !== 16'h0) begin errors++; $display("FAIL busy_mask got %h want 0000", out_b); end
    for (int i = 1; i < 8; i++) tick();
    load = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_sweep_end got %b want 0", busy); end
    checks++;
    if (out !== 16'h0) begin errors++; $display("FAIL write_while_busy got %h want 0000", out); end
    checks++;
    if (out_b !== 16'h0) begin errors++; $display("FAIL old_word_cleared got %h want 0000", out_b); end
  endtask

  task automatic test_clear_priority();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); in_d = 16'(a + 1); load = 1'b1;
      tick();
    end
    load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address_b = 3'(a);
      #1;
      checks++;
      if (out_b !== 16'(a + 1)) begin
        errors++; $display("FAIL fill addr %0d got %h want %h", a, out_b, 16'(a + 1));
      end
    end
    clear = 1'b1; load = 1'b1; address = 3'd0; in_d = 16'hFFFF;
    tick();
    clear = 1'b0; load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy edge %0d got %b want 1", i, busy); end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_done got %b want 0", busy); end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      checks++;
      if (out !== 16'h0) begin errors++; $display("FAIL cleared addr %0d got %h want 0000", a, out); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    address = 3'd1; in_d = 16'h0042; load = 1'b1;
    tick();
    load = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b1 || out !== 16'h0) begin
      errors++; $display("FAIL mid_reset got busy=%b out=%h want 1/0000", busy, out);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy edge %0d got %b want 1", i, busy); end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL restart_done got %b want 0", busy); end
    checks++;
    if (out !== 16'h0) begin errors++; $display("FAIL restart_word got %h want 0000", out); end
  endtask

  task automatic test_param();
    p_reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        checks++;
        if (p_busy !== 1'b1) begin errors++; $display("FAIL p_busy_last got %b want 1", p_busy); end
      end
      tick();
    end
    checks++;
    if (p_busy !== 1'b0) begin errors++; $display("FAIL p_sweep_done got %b want 0", p_busy); end
    p_address = 6'd63; p_in = 8'hA5; p_load = 1'b1;
    tick();
    p_address = 6'd0; p_in = 8'h5A;
    tick();
    p_load = 1'b0; p_address_b = 6'd63;
    #1;
    checks++;
    if (p_out_b !== 8'hA5) begin errors++; $display("FAIL p_outb63 got %h want a5", p_out_b); end
    checks++;
    if (p_out !== 8'h5A) begin errors++; $display("FAIL p_out0 got %h want 5a", p_out); end
    p_address = 6'd62;
    #1;
    checks++;
    if (p_out !== 8'h00) begin errors++; $display("FAIL p_out62 got %h want 00", p_out); end
  endtask

  initial begin
    p_reset = 1'b1; p_load = 1'b0; p_clear = 1'b0;
    p_address = 6'd0; p_address_b = 6'd0; p_in = 8'h0;
    test_reset();
    test_write_read();
    test_write_while_busy();
    test_clear_priority();
    test_reset_mid_sweep();
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
